decoded_op_queue: RTL and testbench

DECODED_OP_QUEUE -- requirements
Module: decoded_op_queue

---
 rtl/decoded_op_queue_pkg.sv | 26 ++
 rtl/decoded_op_queue_if.sv | 35 +++
 rtl/decoded_op_queue_compactor.sv | 47 ++++
 rtl/decoded_op_queue.sv | 83 ++++++++
 tb/tb_decoded_op_queue.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/decoded_op_queue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : OpTypes (package)                                            |
// | Brief    : Shared decoded-op types and default queue sizing.            |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package OpTypes;

  localparam int OPQ_DEPTH     = 8;
  localparam int OPQ_ENQ_WIDTH = 2;

  typedef struct packed {
    logic       isBubble;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } OpInfo;

  typedef struct packed {
    OpInfo       op;
    logic [31:0] pc;
  } OpQueueEntry;

endpackage
`default_nettype wire

// File: rtl/decoded_op_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : decoded_op_queue_if                                          |
// | Brief    : Enqueue/dequeue/flush bundle of the decoded-op queue.        |
// |            master = producer/consumer side, slave = queue side.         |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
interface decoded_op_queue_if
  import OpTypes::*;
#(
  parameter int DEPTH     = OPQ_DEPTH,
  parameter int ENQ_WIDTH = OPQ_ENQ_WIDTH
);

  logic                     flush;
  logic [ENQ_WIDTH-1:0]     enqValid;
  OpQueueEntry              enqEntry [ENQ_WIDTH];
  logic                     enqReady;
  logic                     deqValid;
  OpQueueEntry              deqEntry;
  logic                     deqReady;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, enqValid, enqEntry, deqReady,
    input  enqReady, deqValid, deqEntry, count
  );

  modport slave (
    input  flush, enqValid, enqEntry, deqReady,
    output enqReady, deqValid, deqEntry, count
  );

endinterface
`default_nettype wire

// File: rtl/decoded_op_queue_compactor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : opq_enq_compactor                                            |
// | Brief    : Qualifies enqueue lanes and packs the surviving ones into    |
// |            consecutive write slots (slot 0 lands at the queue tail).    |
// |            OPQ_BUBBLE_SQUASH_EN: drop lanes whose op is a bubble.       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module opq_enq_compactor
  import OpTypes::*;
#(
  parameter int ENQ_WIDTH = OPQ_ENQ_WIDTH
) (
  input  wire logic                 i_accept,
  input  wire logic [ENQ_WIDTH-1:0] i_enqValid,
  input  wire OpQueueEntry          i_enqEntry [ENQ_WIDTH],
  output logic [1:0]                o_wrCount,
  output logic [ENQ_WIDTH-1:0]      o_wrEn,
  output OpQueueEntry               o_wrData [ENQ_WIDTH]
);

  logic [ENQ_WIDTH-1:0] w_laneOk;

  // A lane is written only if the queue accepts this cycle and the lane is valid
  for (genvar i = 0; i < ENQ_WIDTH; i++) begin : g_lane
`ifdef OPQ_BUBBLE_SQUASH_EN
    assign w_laneOk[i] = i_accept & i_enqValid[i] & ~i_enqEntry[i].op.isBubble;
`else
    assign w_laneOk[i] = i_accept & i_enqValid[i];
`endif
  end

  if (ENQ_WIDTH == 2) begin : g_two_lane
    // A dead lane 0 lets lane 1 slide into the tail slot
    assign o_wrData[0] = w_laneOk[0] ? i_enqEntry[0] : i_enqEntry[1];
    assign o_wrData[1] = i_enqEntry[1];
    assign o_wrEn[0]   = |w_laneOk;
    assign o_wrEn[1]   = &w_laneOk;
    assign o_wrCount   = {1'b0, w_laneOk[0]} + {1'b0, w_laneOk[1]};
  end else begin : g_one_lane
    assign o_wrData[0] = i_enqEntry[0];
    assign o_wrEn      = w_laneOk;
    assign o_wrCount   = {1'b0, w_laneOk[0]};
  end

endmodule
`default_nettype wire

// File: rtl/decoded_op_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : decoded_op_queue                                             |
// | Brief    : Circular queue of decoded ops between decode and dispatch.   |
// |            Up to ENQ_WIDTH ops in, one op out per cycle; flush on       |
// |            mispredict. OPQ_BUBBLE_SQUASH_EN: bubbles are not stored.    |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module decoded_op_queue
  import OpTypes::*;
#(
  parameter int DEPTH     = OPQ_DEPTH,
  parameter int ENQ_WIDTH = OPQ_ENQ_WIDTH
) (
  input wire logic          clk,
  input wire logic          rst,
  decoded_op_queue_if.slave q
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  // Highest occupancy that still leaves room for a full-width enqueue
  localparam logic [c_CNT_W-1:0] c_ENQ_LIMIT = c_CNT_W'(DEPTH - ENQ_WIDTH);

  OpQueueEntry          r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_CNT_W-1:0]   r_count;

  logic                 w_enqReady;
  logic                 w_deqValid;
  logic                 w_doDeq;
  logic                 w_accept;
  logic [1:0]           w_wrCount;
  logic [ENQ_WIDTH-1:0] w_wrEn;
  OpQueueEntry          w_wrData [ENQ_WIDTH];

  // Ready looks only at registered occupancy, never at this cycle's dequeue
  assign w_enqReady = (r_count <= c_ENQ_LIMIT);
  assign w_deqValid = (r_count != '0);
  assign w_doDeq    = w_deqValid & q.deqReady & ~q.flush;
  assign w_accept   = w_enqReady & ~q.flush;

  assign q.enqReady = w_enqReady;
  assign q.deqValid = w_deqValid;
  assign q.deqEntry = r_mem[r_head];
  assign q.count    = r_count;

  opq_enq_compactor #(
    .ENQ_WIDTH (ENQ_WIDTH)
  ) u_compactor (
    .i_accept   (w_accept),
    .i_enqValid (q.enqValid),
    .i_enqEntry (q.enqEntry),
    .o_wrCount  (w_wrCount),
    .o_wrEn     (w_wrEn),
    .o_wrData   (w_wrData)
  );

  // Pointer and occupancy update; reset beats flush, flush beats enq/deq
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_PTR_W'(w_doDeq);
      r_tail  <= r_tail + c_PTR_W'(w_wrCount);
      r_count <= r_count + c_CNT_W'(w_wrCount) - c_CNT_W'(w_doDeq);
    end
  end

  // Storage write at tail, wrapping naturally through the pointer width
  always_ff @(posedge clk) begin
    for (int s = 0; s < ENQ_WIDTH; s++) begin
      if (w_wrEn[s]) begin
        r_mem[r_tail + c_PTR_W'(s)] <= w_wrData[s];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoded_op_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_decoded_op_queue                                          |
// | Brief    : Self-checking bench: directed vector table, corner-case      |
// |            sequences and random traffic against a queue model.          |
// |            Honours OPQ_BUBBLE_SQUASH_EN for expected values.            |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_decoded_op_queue;
  import OpTypes::*;

  localparam int DEPTH     = 8;
  localparam int ENQ_WIDTH = 2;
`ifdef OPQ_BUBBLE_SQUASH_EN
  localparam bit SQUASH = 1'b1;
`else
  localparam bit SQUASH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoded_op_queue_if #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH)) bus ();

  decoded_op_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  OpQueueEntry model[$];
  logic [31:0] deqLog[$];

  typedef struct {
    bit          fl;
    bit [1:0]    v;
    bit [31:0]   pc0;
    bit [31:0]   pc1;
    bit          bub0;
    bit          dr;
    int          expCount;
    bit          expDv;
    bit [31:0]   expPc;
  } vec_t;

  vec_t vecs[12];

  function automatic OpQueueEntry mk(input logic [31:0] pc, input logic bub);
    OpQueueEntry e;
    e             = '0;
    e.pc          = pc;
    e.op.isBubble = bub;
    e.op.opcode   = pc[8:2];
    e.op.rd       = pc[6:2] ^ 5'h15;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's occupancy and head
  task automatic compareModel(input string tag);
    chk({tag, ".count"}, 64'(bus.count), 64'(model.size()));
    chk({tag, ".enqReady"}, 64'(bus.enqReady), 64'(model.size() <= DEPTH - ENQ_WIDTH));
    chk({tag, ".deqValid"}, 64'(bus.deqValid), 64'(model.size() != 0));
    if (model.size() != 0)
      chk({tag, ".deqEntry"}, 64'(bus.deqEntry), 64'(model[0]));
  endtask

  // One clock: drive, log any dequeue, clock, update model, compare
  task automatic step(input bit r, input bit fl, input bit [1:0] v,
                      input OpQueueEntry e0, input OpQueueEntry e1,
                      input bit dr, input string tag);
    bit rdy;
    rst             = r;
    bus.flush       = fl;
    bus.enqValid    = v;
    bus.enqEntry[0] = e0;
    bus.enqEntry[1] = e1;
    bus.deqReady    = dr;
    #1;
    if (!r && !fl && dr && bus.deqValid) deqLog.push_back(bus.deqEntry.pc);
    @(posedge clk);
    if (r || fl) begin
      model.delete();
    end else begin
      rdy = (model.size() <= DEPTH - ENQ_WIDTH);
      if (dr && model.size() != 0) void'(model.pop_front());
      if (rdy) begin
        if (v[0] && !(SQUASH && e0.op.isBubble)) model.push_back(e0);
        if (v[1] && !(SQUASH && e1.op.isBubble)) model.push_back(e1);
      end
    end
    #1;
    compareModel(tag);
  endtask

  task automatic idle(input bit dr, input string tag);
    step(1'b0, 1'b0, 2'b00, mk(32'h0, 1'b0), mk(32'h0, 1'b0), dr, tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.enqValid = '0;
    bus.enqEntry[0] = '0;
    bus.enqEntry[1] = '0;
    bus.deqReady = 1'b0;

    // Reset with enqueue pending: must come up empty and ready
    step(1'b1, 1'b0, 2'b11, mk(32'hDEAD0, 1'b0), mk(32'hDEAD4, 1'b0), 1'b1, "reset");
    step(1'b1, 1'b0, 2'b00, mk(32'h0, 1'b0), mk(32'h0, 1'b0), 1'b0, "reset2");
    chk("reset.count", 64'(bus.count), 64'd0);
    chk("reset.deqValid", 64'(bus.deqValid), 64'd0);
    chk("reset.enqReady", 64'(bus.enqReady), 64'd1);

    // Directed vector table: {flush, enqValid, pc0, pc1, bubble0, deqReady} -> {count, deqValid, head pc}
    vecs[0]  = '{0, 2'b11, 32'h100, 32'h104, 0, 0, 2, 1, 32'h100};
    vecs[1]  = '{0, 2'b00, 32'h0,   32'h0,   0, 1, 1, 1, 32'h104};
    vecs[2]  = '{0, 2'b00, 32'h0,   32'h0,   0, 1, 0, 0, 32'h0};
    vecs[3]  = '{0, 2'b10, 32'h1F0, 32'h200, 0, 0, 1, 1, 32'h200};
    vecs[4]  = '{0, 2'b00, 32'h0,   32'h0,   0, 1, 0, 0, 32'h0};
    vecs[5]  = '{0, 2'b11, 32'h500, 32'h504, 0, 0, 2, 1, 32'h500};
    vecs[6]  = '{0, 2'b11, 32'h508, 32'h50C, 0, 0, 4, 1, 32'h500};
    vecs[7]  = '{0, 2'b01, 32'h510, 32'h514, 0, 0, 5, 1, 32'h500};
    vecs[8]  = '{1, 2'b11, 32'h600, 32'h604, 0, 1, 0, 0, 32'h0};
    vecs[9]  = '{0, 2'b00, 32'h0,   32'h0,   0, 1, 0, 0, 32'h0};
`ifdef OPQ_BUBBLE_SQUASH_EN
    vecs[10] = '{0, 2'b11, 32'h2FC, 32'h300, 1, 0, 1, 1, 32'h300};
`else
    vecs[10] = '{0, 2'b11, 32'h2FC, 32'h300, 1, 0, 2, 1, 32'h2FC};
`endif
    vecs[11] = '{1, 2'b00, 32'h0,   32'h0,   0, 0, 0, 0, 32'h0};

    for (int i = 0; i < 12; i++) begin
      step(1'b0, vecs[i].fl, vecs[i].v, mk(vecs[i].pc0, vecs[i].bub0),
           mk(vecs[i].pc1, 1'b0), vecs[i].dr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.count", i), 64'(bus.count), 64'(vecs[i].expCount));
      chk($sformatf("vec%0d.deqValid", i), 64'(bus.deqValid), 64'(vecs[i].expDv));
      if (vecs[i].expDv)
        chk($sformatf("vec%0d.headPc", i), 64'(bus.deqEntry.pc), 64'(vecs[i].expPc));
    end

    // Near-full boundary: 7 entries blocks a 2-wide enqueue
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 2'b11, mk(32'h700 + 8 * k, 1'b0), mk(32'h704 + 8 * k, 1'b0), 1'b0, "fill");
    step(1'b0, 1'b0, 2'b01, mk(32'h718, 1'b0), mk(32'h71C, 1'b0), 1'b0, "fill7");
    chk("full7.count", 64'(bus.count), 64'd7);
    chk("full7.enqReady", 64'(bus.enqReady), 64'd0);
    step(1'b0, 1'b0, 2'b11, mk(32'h7A0, 1'b0), mk(32'h7A4, 1'b0), 1'b0, "blocked");
    chk("blocked.count", 64'(bus.count), 64'd7);
    idle(1'b1, "deq1");
    chk("deq1.count", 64'(bus.count), 64'd6);
    chk("deq1.enqReady", 64'(bus.enqReady), 64'd1);
    step(1'b0, 1'b0, 2'b11, mk(32'h720, 1'b0), mk(32'h724, 1'b0), 1'b1, "enq2deq1");
    chk("enq2deq1.count", 64'(bus.count), 64'd7);
    chk("enq2deq1.headPc", 64'(bus.deqEntry.pc), 64'h708);
    step(1'b0, 1'b1, 2'b00, mk(32'h0, 1'b0), mk(32'h0, 1'b0), 1'b0, "flush");

    // Twenty enqueue/dequeue rounds across the pointer wrap, order must hold
    deqLog.delete();
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 1)
        step(1'b0, 1'b0, 2'b11, mk(32'h1000 + 8 * (k / 2), 1'b0),
             mk(32'h1004 + 8 * (k / 2), 1'b0), 1'b1, "wrap");
      else
        idle(1'b1, "wrap");
    end
    for (int k = 0; k < 16 && bus.deqValid; k++) idle(1'b1, "drain");
    chk("wrap.drained", 64'(bus.deqValid), 64'd0);
    chk("wrap.logSize", 64'(deqLog.size()), 64'd20);
    for (int k = 0; k < deqLog.size() && k < 20; k++)
      chk($sformatf("wrap.order%0d", k), 64'(deqLog[k]), 64'(32'h1000 + 4 * k));

    // Random traffic, including occasional flush, bubbles and mid-run reset
    for (int n = 0; n < 600; n++) begin
      bit r, fl;
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 31) == 0);
      step(r, fl, 2'($urandom), mk($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0)),
           mk($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0)),
           1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
